// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared off-chip block memory port between the I-cache and D-cache.
// Optional build macro ARB_ROUND_ROBIN_EN: alternate grants under contention instead of D-cache priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read,
    input  logic              ic_write,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [DATA_W-1:0] ic_wdata,
    output logic              ic_ready,
    output logic [DATA_W-1:0] ic_rdata,
    input  logic              dc_read,
    input  logic              dc_write,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_DC, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic ic_act, dc_act, pick_dc, win_write;

    assign ic_act = ic_read | ic_write;
    assign dc_act = dc_read | dc_write;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers who was served last; only consulted when both caches contend.
    logic last_dc_q, last_dc_d;
    assign pick_dc = dc_act & (~ic_act | ~last_dc_q);
`else
    assign pick_dc = dc_act;
`endif

    // A write request dominates a simultaneous read from the same cache.
    assign win_write = pick_dc ? dc_write : ic_write;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_dc_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_dc_q   <= last_dc_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_dc_d   = last_dc_q;
`endif
        case (state_q)
            IDLE: begin
                if (ic_act | dc_act) begin
                    state_d     = pick_dc ? BUSY_DC : BUSY_IC;
                    mem_addr_d  = pick_dc ? dc_addr : ic_addr;
                    mem_wdata_d = pick_dc ? dc_wdata : ic_wdata;
                    mem_write_d = win_write;
                    mem_read_d  = ~win_write;
                end
            end
            BUSY_IC, BUSY_DC: begin
                if (mem_ready) begin
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RELEASE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_dc_d   = (state_q == BUSY_DC);
`endif
                end
            end
            // Idle port cycle so the served cache can withdraw its request.
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ic_ready = 1'b0;
        dc_ready = 1'b0;
        ic_rdata = '0;
        dc_rdata = '0;
        if (state_q == BUSY_IC) begin
            ic_ready = mem_ready;
            ic_rdata = mem_rdata;
        end
        if (state_q == BUSY_DC) begin
            dc_ready = mem_ready;
            dc_rdata = mem_rdata;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam logic [DW-1:0] PATTERN = 128'h0123456789ABCDEF00000000DEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ic_read = 1'b0, ic_write = 1'b0, dc_read = 1'b0, dc_write = 1'b0;
    logic [AW-1:0] ic_addr = '0, dc_addr = '0;
    logic [DW-1:0] ic_wdata = '0, dc_wdata = '0;
    logic ic_ready, dc_ready, mem_read, mem_write;
    logic [DW-1:0] ic_rdata, dc_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_assert = 0, n_fail = 0, cyc = 0;

    // model: owner 0=none 1=IC 2=DC, plus release flag
    int m_own = 0, m_last = 1;
    bit m_rel = 0, m_dcw = 0;
    logic m_rd = 1'b0, m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;

    int ic_rdy_cnt = 0, dc_rdy_cnt = 0, strobe_cycles = 0, start_cyc = 0;
    logic st_rd = 1'b0, st_wr = 1'b0;
    logic [AW-1:0] st_addr = '0;
    bit prev_strobe = 0;

    bit rand_en = 0, new_en = 0, ic_on = 0, dc_on = 0;
    int spur_pct = 0, mdelay = 4, mcnt = 0, ic_seen = 0, dc_seen = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .ic_read(ic_read), .ic_write(ic_write), .ic_addr(ic_addr), .ic_wdata(ic_wdata),
        .ic_ready(ic_ready), .ic_rdata(ic_rdata),
        .dc_read(dc_read), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: one transaction in flight, then one quiet cycle, then arbitration.
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_own = 0; m_rel = 0; m_rd = 1'b0; m_wr = 1'b0;
            m_addr = '0; m_wdata = '0; m_last = 1;
        end else if (m_rel) begin
            m_rel = 0;
        end else if (m_own != 0) begin
            if (mem_ready) begin
                m_rd = 1'b0; m_wr = 1'b0; m_last = m_own; m_own = 0; m_rel = 1;
            end
        end else if (ic_read || ic_write || dc_read || dc_write) begin
            m_dcw = (dc_read || dc_write) && (!(ic_read || ic_write) || !RR || m_last == 1);
            if (m_dcw) begin
                m_own = 2; m_addr = dc_addr; m_wdata = dc_wdata; m_wr = dc_write;
            end else begin
                m_own = 1; m_addr = ic_addr; m_wdata = ic_wdata; m_wr = ic_write;
            end
            m_rd = !m_wr;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("mem_read", 128'(mem_read), 128'(m_rd));
            chk("mem_write", 128'(mem_write), 128'(m_wr));
            chk("mem_addr", 128'(mem_addr), 128'(m_addr));
            chk("mem_wdata", mem_wdata, m_wdata);
            chk("ic_ready", 128'(ic_ready), 128'(mem_ready && m_own == 1));
            chk("dc_ready", 128'(dc_ready), 128'(mem_ready && m_own == 2));
            chk("ic_rdata", ic_rdata, (m_own == 1) ? mem_rdata : '0);
            chk("dc_rdata", dc_rdata, (m_own == 2) ? mem_rdata : '0);
        end
        if (ic_ready) ic_rdy_cnt++;
        if (dc_ready) dc_rdy_cnt++;
        if (mem_read || mem_write) begin
            strobe_cycles++;
            if (!prev_strobe) begin
                start_cyc = cyc; st_rd = mem_read; st_wr = mem_write; st_addr = mem_addr;
            end
        end
        prev_strobe = mem_read || mem_write;
    end

    task automatic rand_req(input int cnt, inout int seen, inout bit on, inout logic rd,
                            inout logic wr, inout logic [AW-1:0] a, inout logic [DW-1:0] wd);
        int k;
        if (on) begin
            if (cnt != seen) begin
                seen = cnt; on = 0; rd = 1'b0; wr = 1'b0;
            end
        end else if (new_en && $urandom_range(99) < 35) begin
            k = $urandom_range(2);
            on = 1; rd = (k != 1); wr = (k != 0);
            a = AW'($urandom);
            wd = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Advance to just after the next rising edge and drive that cycle's inputs.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (mem_read || mem_write) begin
            if (mcnt >= mdelay - 1) begin
                mem_ready = 1'b1; mcnt = 0;
            end else begin
                mem_ready = 1'b0; mcnt++;
            end
        end else begin
            mcnt = 0;
            mem_ready = ($urandom_range(99) < spur_pct);
            if (rand_en) mdelay = $urandom_range(5, 1);
        end
        mem_rdata = rand_en ? {$urandom, $urandom, $urandom, $urandom} : PATTERN;
        if (rand_en) begin
            rand_req(ic_rdy_cnt, ic_seen, ic_on, ic_read, ic_write, ic_addr, ic_wdata);
            rand_req(dc_rdy_cnt, dc_seen, dc_on, dc_read, dc_write, dc_addr, dc_wdata);
        end
    endtask

    task automatic wait_ready(output int who, output int at, output logic [DW-1:0] rd);
        who = 0; at = 0; rd = '0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            @(negedge clk);
            if (dc_ready) begin who = 2; at = cyc; rd = dc_rdata; break; end
            if (ic_ready) begin who = 1; at = cyc; rd = ic_rdata; break; end
        end
        cycle();
        if (who == 1) begin ic_read = 1'b0; ic_write = 1'b0; end
        if (who == 2) begin dc_read = 1'b0; dc_write = 1'b0; end
    endtask

    initial begin
        int who, at, at2, c0, c1, s0, rq;
        logic [DW-1:0] rd;

        repeat (2) cycle();
        chk("rst_mem_read", 128'(mem_read), 128'(0));
        chk("rst_mem_write", 128'(mem_write), 128'(0));
        chk("rst_mem_addr", 128'(mem_addr), 128'(0));
        chk("rst_mem_wdata", mem_wdata, 128'(0));
        chk("rst_readys", 128'({ic_ready, dc_ready}), 128'(0));
        chk("rst_rdata", ic_rdata | dc_rdata, 128'(0));
        rst = 1'b0;
        repeat (2) cycle();

        // lone D-cache read, memory answers on the 4th strobe cycle
        mdelay = 4;
        s0 = strobe_cycles; c0 = ic_rdy_cnt; c1 = dc_rdy_cnt;
        cycle();
        dc_read = 1'b1; dc_addr = 28'h0000010; rq = cyc;
        @(negedge clk);
        chk("t1_no_strobe_yet", 128'(mem_read), 128'(0));
        wait_ready(who, at, rd);
        chk("t1_who", 128'(who), 128'(2));
        chk("t1_rdata", rd, PATTERN);
        chk("t1_strobe_latency", 128'(start_cyc - rq), 128'(1));
        chk("t1_addr", 128'(st_addr), 128'(28'h10));
        repeat (3) cycle();
        chk("t1_strobe_cycles", 128'(strobe_cycles - s0), 128'(4));
        chk("t1_dc_pulses", 128'(dc_rdy_cnt - c1), 128'(1));
        chk("t1_ic_pulses", 128'(ic_rdy_cnt - c0), 128'(0));

        // simultaneous I-read and D-write
        mdelay = 3;
        cycle();
        ic_read = 1'b1; ic_addr = 28'h40;
        dc_write = 1'b1; dc_addr = 28'h20; dc_wdata = {4{32'h11111111}};
        wait_ready(who, at, rd);
        chk("t2_first", 128'(who), 128'(RR ? 1 : 2));
        chk("t2_first_wr", 128'(st_wr), 128'(RR ? 0 : 1));
        chk("t2_first_addr", 128'(st_addr), 128'(RR ? 28'h40 : 28'h20));
        wait_ready(who, at2, rd);
        chk("t2_second", 128'(who), 128'(RR ? 2 : 1));
        chk("t2_spacing", 128'(start_cyc - at), 128'(3));
        repeat (2) cycle();

        // sustained contention: served cache re-requests right after release
        cycle();
        ic_read = 1'b1; ic_addr = 28'h44; dc_read = 1'b1; dc_addr = 28'h24;
        for (int k = 0; k < 4; k++) begin
            wait_ready(who, at, rd);
            chk("t3_grant", 128'(who), 128'(RR ? ((k % 2 == 0) ? 1 : 2) : 2));
            cycle();
            if (who == 1) ic_read = 1'b1;
            if (who == 2) dc_read = 1'b1;
        end
        ic_read = 1'b0; dc_read = 1'b0;
        repeat (3) cycle();

        // read and write together from one cache
        cycle();
        dc_read = 1'b1; dc_write = 1'b1; dc_addr = 28'h30; dc_wdata = {4{32'hA5A5A5A5}};
        wait_ready(who, at, rd);
        chk("t4_who", 128'(who), 128'(2));
        chk("t4_wr", 128'(st_wr), 128'(1));
        chk("t4_rd", 128'(st_rd), 128'(0));
        chk("t4_addr", 128'(st_addr), 128'(28'h30));
        repeat (2) cycle();

        // reset while the D-cache transaction is outstanding
        mdelay = 8;
        cycle();
        dc_read = 1'b1; dc_addr = 28'h50;
        repeat (3) cycle();
        c1 = dc_rdy_cnt;
        chk("t5_busy", 128'(mem_read), 128'(1));
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_read", 128'(mem_read), 128'(0));
        chk("t5_rst_addr", 128'(mem_addr), 128'(0));
        dc_read = 1'b0;
        #1 rst = 1'b0;
        cycle();
        chk("t5_idle_after", 128'(mem_read), 128'(0));
        dc_read = 1'b1; dc_addr = 28'h60;
        wait_ready(who, at, rd);
        chk("t5_new_who", 128'(who), 128'(2));
        chk("t5_new_addr", 128'(st_addr), 128'(28'h60));
        chk("t5_pulses", 128'(dc_rdy_cnt - c1), 128'(1));
        repeat (2) cycle();

        // mem_ready held high whenever the port is idle
        mdelay = 3; spur_pct = 100;
        cycle();
        s0 = strobe_cycles; c0 = ic_rdy_cnt; c1 = dc_rdy_cnt;
        repeat (4) cycle();
        chk("t6_idle_pulses", 128'((ic_rdy_cnt - c0) + (dc_rdy_cnt - c1)), 128'(0));
        chk("t6_idle_strobe", 128'(strobe_cycles - s0), 128'(0));
        ic_read = 1'b1; ic_addr = 28'h70;
        wait_ready(who, at, rd);
        chk("t6_who", 128'(who), 128'(1));
        repeat (4) cycle();
        chk("t6_ic_pulses", 128'(ic_rdy_cnt - c0), 128'(1));
        chk("t6_dc_pulses", 128'(dc_rdy_cnt - c1), 128'(0));
        chk("t6_strobe", 128'(strobe_cycles - s0), 128'(3));
        spur_pct = 0;

        // random traffic
        ic_seen = ic_rdy_cnt; dc_seen = dc_rdy_cnt; ic_on = 0; dc_on = 0;
        c0 = ic_rdy_cnt; c1 = dc_rdy_cnt;
        spur_pct = 15; new_en = 1; rand_en = 1;
        repeat (3000) cycle();
        new_en = 0; spur_pct = 0;
        for (int i = 0; i < 200 && (ic_on || dc_on); i++) cycle();
        chk("rand_drain", 128'(ic_on || dc_on), 128'(0));
        chk("rand_progress", 128'((ic_rdy_cnt - c0) > 20 && (dc_rdy_cnt - c1) > 20), 128'(1));
        rand_en = 0;
        repeat (3) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
